// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches one word per instruction over a
// req/rvalid handshake and presents it to the control decoder until it retires.
module instr_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] target,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic {FETCH, VALID} state_t;

  state_t          state, state_next;
  logic            capture, retire;
  logic [XLEN-1:0] pc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  // The request is gated by rst_n so memory sees it drop the moment reset asserts.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    retire     = 1'b0;
    imem_req   = 1'b0;
    case (state)
      FETCH: begin
        imem_req = rst_n;
        if (imem_rvalid) begin
          capture    = 1'b1;
          state_next = VALID;
        end
      end
      VALID: begin
        if (!stall) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  assign pc_next = pc_sel ? {target[XLEN-1:2], 2'b00} : pc_plus4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      instr      <= NOP;
      misaligned <= 1'b0;
    end else begin
      misaligned <= retire && pc_sel && (target[1:0] != 2'b00);
      if (capture) instr <= imem_rdata;
      if (retire)  pc    <= pc_next;
    end
  end

  assign instr_valid = (state == VALID);
  assign imem_addr   = pc;
  assign pc_plus4    = pc + XLEN'(4);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a behavioural model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_sel, stall, imem_rvalid;
  logic [31:0] target, imem_rdata;
  logic        imem_req, instr_valid, misaligned;
  logic [31:0] imem_addr, instr, pc, pc_plus4;

  logic        w_pc_sel, w_stall, w_rvalid;
  logic [31:0] w_target, w_rdata;
  logic        w_req, w_instr_valid, w_misaligned;
  logic [31:0] w_addr, w_instr, w_pc, w_pc_plus4;

  int checks = 0;
  int errors = 0;

  // Behavioural view: which word is in hand, at which address, and whether it is valid.
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_instr = 32'h0000_0013;
  logic        m_valid = 1'b0;
  logic        m_mis   = 1'b0;

  always #5 clk = ~clk;

  instr_fetch u_dut (
    .clk(clk), .rst_n(rst_n), .pc_sel(pc_sel), .target(target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid), .pc(pc),
    .pc_plus4(pc_plus4), .misaligned(misaligned)
  );

  instr_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .pc_sel(w_pc_sel), .target(w_target), .stall(w_stall),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rvalid(w_rvalid),
    .imem_rdata(w_rdata), .instr(w_instr), .instr_valid(w_instr_valid), .pc(w_pc),
    .pc_plus4(w_pc_plus4), .misaligned(w_misaligned)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: a word arrives while waiting, or the held word retires to a new PC.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc    = 32'h0;
      m_instr = 32'h0000_0013;
      m_valid = 1'b0;
      m_mis   = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (!m_valid) begin
        if (imem_rvalid) begin
          m_instr = imem_rdata;
          m_valid = 1'b1;
        end
      end else if (!stall) begin
        if (pc_sel) begin
          m_pc  = (target / 4) * 4;
          m_mis = (target % 4) != 0;
        end else begin
          m_pc = m_pc + 32'd4;
        end
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    checkOutput("model_req",        {31'b0, imem_req},    {31'b0, rst_n && !m_valid});
    checkOutput("model_addr",       imem_addr,            m_pc);
    checkOutput("model_pc",         pc,                   m_pc);
    checkOutput("model_pc_plus4",   pc_plus4,             m_pc + 32'd4);
    checkOutput("model_instr",      instr,                m_instr);
    checkOutput("model_valid",      {31'b0, instr_valid}, {31'b0, m_valid});
    checkOutput("model_misaligned", {31'b0, misaligned},  {31'b0, m_mis});
  end

  task automatic applyStimulus();
    @(negedge clk);
    stall       = ($urandom_range(0, 3) == 0);
    imem_rvalid = ($urandom_range(0, 2) == 0);
    imem_rdata  = $urandom;
    pc_sel      = $urandom_range(0, 1) == 1;
    target      = $urandom;
  endtask

  initial begin
    rst_n = 1'b0; pc_sel = 1'b0; stall = 1'b0; imem_rvalid = 1'b0;
    target = 32'h0; imem_rdata = 32'h0;
    w_pc_sel = 1'b0; w_stall = 1'b0; w_rvalid = 1'b0; w_target = 32'h0; w_rdata = 32'h0;

    repeat (2) @(negedge clk);
    checkOutput("reset_req",     {31'b0, imem_req},    32'h0);
    checkOutput("reset_pc",      pc,                   32'h0);
    checkOutput("reset_instr",   instr,                32'h0000_0013);
    checkOutput("reset_valid",   {31'b0, instr_valid}, 32'h0);
    checkOutput("wrap_reset_pc", w_pc,                 32'hFFFF_FFFC);
    rst_n = 1'b1;

    @(negedge clk);
    checkOutput("first_req",  {31'b0, imem_req}, 32'h1);
    checkOutput("first_addr", imem_addr,         32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    w_rvalid = 1'b1; w_rdata = 32'h0000_0013;

    @(negedge clk);
    imem_rvalid = 1'b0; w_rvalid = 1'b0;
    checkOutput("first_instr",    instr,                32'h0050_0093);
    checkOutput("first_valid",    {31'b0, instr_valid}, 32'h1);
    checkOutput("first_pc",       pc,                   32'h0);
    checkOutput("first_pc_plus4", pc_plus4,             32'h4);
    checkOutput("wrap_pc_plus4",  w_pc_plus4,           32'h0);
    stall = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      imem_rvalid = (i % 2 == 0);
      imem_rdata  = 32'hDEAD_BEEF;
      checkOutput("stall_instr", instr,                32'h0050_0093);
      checkOutput("stall_pc",    pc,                   32'h0);
      checkOutput("stall_req",   {31'b0, imem_req},    32'h0);
      checkOutput("stall_valid", {31'b0, instr_valid}, 32'h1);
      if (i == 0) begin
        checkOutput("wrap_addr", w_addr,            32'h0);
        checkOutput("wrap_req",  {31'b0, w_req},    32'h1);
      end
    end

    @(negedge clk);
    imem_rvalid = 1'b0; stall = 1'b0; pc_sel = 1'b0;
    @(negedge clk);
    checkOutput("seq_addr",  imem_addr,            32'h4);
    checkOutput("seq_valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("seq_req",   {31'b0, imem_req},    32'h1);
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;

    @(negedge clk);
    imem_rvalid = 1'b0;
    checkOutput("second_pc", pc, 32'h4);
    pc_sel = 1'b1; target = 32'h0000_0102;

    @(negedge clk);
    pc_sel = 1'b0;
    checkOutput("branch_addr",   imem_addr,           32'h100);
    checkOutput("branch_misal",  {31'b0, misaligned}, 32'h1);

    @(negedge clk);
    checkOutput("branch_misal_clear", {31'b0, misaligned}, 32'h0);
    checkOutput("branch_hold_addr",   imem_addr,           32'h100);

    // Pull reset in the middle of an outstanding request.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_req", {31'b0, imem_req}, 32'h0);
    checkOutput("midreset_pc",  pc,                32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("restart_req",  {31'b0, imem_req}, 32'h1);
    checkOutput("restart_addr", imem_addr,         32'h0);

    for (int i = 0; i < 3000; i++) applyStimulus();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
